urv_dmem_ctrl: RTL
==================

Name: urv_dmem_ctrl

Overview:
- Data-memory access controller between the execute stage and the writeback stage.
- Takes the load/store held in the X stage and runs one request/ready transaction on the external data bus.
- For stores, generates byte selects and lane-replicated store data.
- Returns the raw 32-bit load word plus load/store done flags. Writeback consumes these for load extraction and for releasing its stall request.

Parameters:
- DM_ADDR_WIDTH, 32, width of dm_addr_o. Taken from x_dm_addr_i[DM_ADDR_WIDTH-1:0] with bits [1:0] forced to 0.

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  synchronous reset, active-low (0 = reset)
- x_valid_i  in  1  X-stage instruction valid
- x_load_i  in  1  X-stage instruction is a load
- x_store_i  in  1  X-stage instruction is a store
- x_fun_i  in  3  access size: 000 B, 001 H, 010 L(word), 100 BU, 101 HU
- x_dm_addr_i  in  32  effective byte address
- x_rs2_value_i  in  32  store source data
- w_stall_i  in  1  pipeline stall; X instruction does not retire this cycle
- dm_addr_o  out  DM_ADDR_WIDTH  word-aligned bus address
- dm_data_s_o  out  32  store data, lane-replicated
- dm_data_select_o  out  4  byte enables
- dm_load_o  out  1  load strobe, held until dm_ready_i
- dm_store_o  out  1  store strobe, held until dm_ready_i
- dm_ready_i  in  1  bus completion; load data valid on dm_data_l_i this cycle
- dm_data_l_i  in  32  bus read data
- dm_data_l_o  out  32  registered raw load word to writeback
- dm_load_done_o  out  1  load complete, data valid
- dm_store_done_o  out  1  store complete
- dm_misaligned_o  out  1  misaligned access flag (optional feature)

Behaviour:
- Reset (rst_i=0 at an edge):
  - State goes to IDLE.
  - All outputs go to 0: strobes, selects, address, store data, load data, done flags, dm_misaligned_o.
  - Reset mid-transaction drops the strobe at that edge; the bus slave tolerates the abort.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If x_valid_i & (x_load_i | x_store_i), register address, select and store data, set the matching strobe, and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - Strobe and all bus outputs stay stable until dm_ready_i.
  - On dm_ready_i: clear the strobe; for a load, capture dm_data_l_i into dm_data_l_o; go to DONE.
  - Once issued, a transaction always completes, even if x_valid_i drops.
- DONE:
  - dm_load_done_o or dm_store_done_o = 1 (matching the access type) only while x_valid_i = 1.
  - If !w_stall_i or !x_valid_i: go to IDLE and clear the done flags at that edge.
  - Otherwise hold DONE; flags and dm_data_l_o stay stable.
- Latency:
  - Strobe asserts 1 cycle after the request is seen.
  - Done asserts 1 cycle after dm_ready_i.
  - Minimum 3 cycles per access; a new access can be seen in IDLE the cycle after retire.
- Byte selects:
  - B/BU: 4'b0001 << addr[1:0]
  - H/HU: addr[1] ? 4'b1100 : 4'b0011
  - L: 4'b1111
- Store data:
  - B: {4{rs2[7:0]}}
  - H: {2{rs2[15:0]}}
  - L: rs2
- Load accesses drive dm_data_select_o with the same pattern as stores (informational only).
- Reserved x_fun_i values (011, 110, 111) are treated as L.
- The load and store flags are never both 1; if both arrive, load wins.

Optional Feature:
- Macro: URV_DM_MISALIGN_EN
- Enabled:
  - Misaligned accesses are H/HU with addr[0]=1, or L with addr[1:0]≠0.
  - These go IDLE→DONE directly with no bus strobe.
  - The matching done flag and dm_misaligned_o are asserted, and dm_data_l_o = 0, so writeback never hangs.
  - dm_misaligned_o clears when leaving DONE.
- Disabled:
  - No check; the access proceeds using the low address bits as given.
  - dm_misaligned_o tied to 0.

Test Plan:
- Load word at addr 0x100, dm_ready_i 2 cycles after strobe with data 0xDEADBEEF:
  - dm_addr_o = 0x100, select = 1111.
  - dm_load_done_o = 1 with dm_data_l_o = 0xDEADBEEF one cycle after ready.
  - Returns to IDLE when w_stall_i = 0.
- Store byte rs2 = 0x000000A5 at 0x203:
  - select = 1000, dm_data_s_o = 0xA5A5A5A5.
  - dm_store_done_o pulses after ready.
- Store half rs2 = 0x1234 at 0x42:
  - select = 1100, dm_data_s_o = 0x12341234, dm_addr_o = 0x40.
- Load held in DONE with w_stall_i = 1 for 3 cycles:
  - Done and data stable for 3 cycles.
  - A back-to-back second load issues its strobe in the cycle after retire.
- Reset (rst_i = 0) during REQ with the strobe high:
  - Strobe, done flags and data are 0 after that edge; the FSM stays in IDLE until a new request.
- With URV_DM_MISALIGN_EN, load word at 0x101:
  - No dm_load_o.
  - Next cycle dm_load_done_o = 1, dm_misaligned_o = 1, dm_data_l_o = 0.

Source files
------------

// File: rtl/urv_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : urv_dmem_ctrl
//  Purpose  : Data-memory access controller between X and writeback stages.
//             Optional misalignment trap: define URV_DM_MISALIGN_EN.
//  Revision : 1.0  initial release
// ============================================================================
module urv_dmem_ctrl #(
    parameter int DM_ADDR_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     x_valid_i,
    input  logic                     x_load_i,
    input  logic                     x_store_i,
    input  logic [2:0]               x_fun_i,
    input  logic [31:0]              x_dm_addr_i,
    input  logic [31:0]              x_rs2_value_i,
    input  logic                     w_stall_i,

    output logic [DM_ADDR_WIDTH-1:0] dm_addr_o,
    output logic [31:0]              dm_data_s_o,
    output logic [3:0]               dm_data_select_o,
    output logic                     dm_load_o,
    output logic                     dm_store_o,
    input  logic                     dm_ready_i,
    input  logic [31:0]              dm_data_l_i,

    output logic [31:0]              dm_data_l_o,
    output logic                     dm_load_done_o,
    output logic                     dm_store_done_o,
    output logic                     dm_misaligned_o
);

`ifdef URV_DM_MISALIGN_EN
    localparam bit c_misalign_en = 1'b1;
`else
    localparam bit c_misalign_en = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DM_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]              r_data_s;
    logic [3:0]               r_sel;
    logic                     r_load;
    logic                     r_store;
    logic [31:0]              r_data_l;
    logic                     r_load_done;
    logic                     r_store_done;
    logic                     r_misaligned;

    logic                     w_req;
    logic                     w_is_byte;
    logic                     w_is_half;
    logic                     w_misaligned;
    logic                     w_retire;
    logic [3:0]               w_sel;
    logic [31:0]              w_data_s;
    logic                     w_unused;

    // x_fun_i[2] only selects sign extension, which writeback performs.
    assign w_unused = x_fun_i[2];

    // Reserved size codes (x11, 110) fall through to the word case.
    assign w_is_byte = (x_fun_i[1:0] == 2'b00);
    assign w_is_half = (x_fun_i[1:0] == 2'b01);
    assign w_req     = x_valid_i & (x_load_i | x_store_i);
    assign w_retire  = ~w_stall_i | ~x_valid_i;

    assign w_misaligned = c_misalign_en &
                          ((w_is_half & x_dm_addr_i[0]) |
                           (~w_is_byte & ~w_is_half & (x_dm_addr_i[1:0] != 2'b00)));

    always_comb begin
        w_sel    = 4'b1111;
        w_data_s = x_rs2_value_i;
        if (w_is_byte) begin
            w_sel    = 4'b0001 << x_dm_addr_i[1:0];
            w_data_s = {4{x_rs2_value_i[7:0]}};
        end else if (w_is_half) begin
            w_sel    = x_dm_addr_i[1] ? 4'b1100 : 4'b0011;
            w_data_s = {2{x_rs2_value_i[15:0]}};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_misaligned ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (dm_ready_i) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_retire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_addr       <= '0;
            r_data_s     <= '0;
            r_sel        <= '0;
            r_load       <= 1'b0;
            r_store      <= 1'b0;
            r_data_l     <= '0;
            r_load_done  <= 1'b0;
            r_store_done <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr   <= {x_dm_addr_i[DM_ADDR_WIDTH-1:2], 2'b00};
                        r_sel    <= w_sel;
                        r_data_s <= w_data_s;
                        if (w_misaligned) begin
                            // Skip the bus entirely so writeback is released at once.
                            r_load_done  <= x_load_i;
                            r_store_done <= ~x_load_i;
                            r_misaligned <= 1'b1;
                            r_data_l     <= '0;
                        end else begin
                            r_load  <= x_load_i;
                            r_store <= ~x_load_i;
                        end
                    end
                end
                ST_REQ: begin
                    if (dm_ready_i) begin
                        r_load       <= 1'b0;
                        r_store      <= 1'b0;
                        r_load_done  <= r_load;
                        r_store_done <= r_store;
                        if (r_load) begin
                            r_data_l <= dm_data_l_i;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_retire) begin
                        r_load_done  <= 1'b0;
                        r_store_done <= 1'b0;
                        r_misaligned <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dm_addr_o        = r_addr;
    assign dm_data_s_o      = r_data_s;
    assign dm_data_select_o = r_sel;
    assign dm_load_o        = r_load;
    assign dm_store_o       = r_store;
    assign dm_data_l_o      = r_data_l;
    assign dm_load_done_o   = r_load_done & x_valid_i;
    assign dm_store_done_o  = r_store_done & x_valid_i;
    assign dm_misaligned_o  = c_misalign_en ? r_misaligned : 1'b0;

endmodule
`default_nettype wire
